// File: rtl/softmax_max_ctrl.sv
// Streaming max-search controller for softmax: scans NUM_ELEM signed elements and drives an external max register.
// Optional argmax output idx_out is enabled by defining SOFTMAX_MAX_CTRL_ARGMAX_EN.
module softmax_max_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ELEM   = 8,
  localparam int CNT_W     = $clog2(NUM_ELEM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  set_reg,
  output logic [DATA_WIDTH-1:0] reg_in,
  input  logic [DATA_WIDTH-1:0] reg_out,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] max_out,
`ifdef SOFTMAX_MAX_CTRL_ARGMAX_EN
  output logic [CNT_W-1:0]      idx_out,
`endif
  output logic [1:0]            state_dbg
);

  // Handshake: an element is consumed on a rising edge where in_valid && in_ready;
  // in_ready does not depend on in_valid, and in_data must be stable while in_valid is high.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    set_reg  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FIRST;
          cnt_d   = '0;
        end
      end
      S_FIRST: begin
        in_ready = 1'b1;
        // The first element always seeds the register, whatever it held before.
        if (in_valid) begin
          set_reg = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = (NUM_ELEM == 1) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Strict compare so ties keep the earliest element.
          set_reg = $signed(in_data) > $signed(reg_out);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_ELEM - 1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_in    = in_data;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign max_out   = reg_out;
  assign state_dbg = state_q;

`ifdef SOFTMAX_MAX_CTRL_ARGMAX_EN
  // Captures the pre-increment count, i.e. the zero-based position of the loaded element.
  logic [CNT_W-1:0] idx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 idx_q <= '0;
    else if (in_ready && in_valid && set_reg) idx_q <= cnt_q;
  end
  assign idx_out = idx_q;
`endif

endmodule

// File: tb/tb_softmax_max_ctrl.sv
// Bench for softmax_max_ctrl: directed vector table, start/reset corner sequences and random vectors vs a reference model.
module tb_softmax_max_ctrl;
  localparam int DW = 16;
  localparam int NE = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, set_reg, busy, done;
  logic [DW-1:0] reg_in, reg_out, max_out;
  logic [1:0]    state_dbg;
`ifdef SOFTMAX_MAX_CTRL_ARGMAX_EN
  logic [CW-1:0] idx_out;
`endif

  int checks = 0;
  int errors = 0;

  softmax_max_ctrl #(.DATA_WIDTH(DW), .NUM_ELEM(NE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .set_reg(set_reg), .reg_in(reg_in), .reg_out(reg_out),
    .busy(busy), .done(done), .max_out(max_out),
`ifdef SOFTMAX_MAX_CTRL_ARGMAX_EN
    .idx_out(idx_out),
`endif
    .state_dbg(state_dbg)
  );

  // clock / external max register
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       reg_out <= '0;
    else if (set_reg) reg_out <= reg_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: max is the first occurrence of the largest signed value; a beat loads
  // the register when it is the first element or strictly beats everything before it.
  function automatic void ref_model(input logic [NE-1:0][DW-1:0] d, output logic [DW-1:0] mx,
                                    output int ix, output logic [NE-1:0] loads);
    mx = d[0]; ix = 0; loads = '0; loads[0] = 1'b1;
    for (int i = 1; i < NE; i++)
      if ($signed(d[i]) > $signed(mx)) begin
        mx = d[i]; ix = i; loads[i] = 1'b1;
      end
  endfunction

  function automatic logic [NE-1:0][DW-1:0] v4(input int a, input int b, input int c, input int e);
    v4[0] = DW'(a); v4[1] = DW'(b); v4[2] = DW'(c); v4[3] = DW'(e);
  endfunction

  // driver: one complete vector with optional idle gaps and stray start pulses
  task automatic run_vec(input logic [NE-1:0][DW-1:0] d, input logic [NE-1:0][1:0] gaps,
                         input logic [DW-1:0] exp_max, input int exp_idx, input logic pulse);
    logic [DW-1:0]   mx;
    int              ix;
    logic [NE-1:0]   loads;
    ref_model(d, mx, ix, loads);
    @(negedge clk); start = 1'b1;
    #1 check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 0);
    @(negedge clk); start = 1'b0;
    #1 check("first_busy", busy, 1);
    for (int i = 0; i < NE; i++) begin
      for (int g = 0; g < int'(gaps[i]); g++) begin
        in_valid = 1'b0; in_data = $urandom;
        #1 check("stall_set", set_reg, 0);
        check("stall_ready", in_ready, 1);
        check("stall_done", done, 0);
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = d[i];
      start = (pulse && i == 2);
      #1 check("beat_ready", in_ready, 1);
      check("beat_set", set_reg, loads[i]);
      check("beat_reg_in", reg_in, d[i]);
      check("beat_done", done, 0);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    start = pulse;
    #1 check("done_pulse", done, 1);
    check("done_ready", in_ready, 0);
    check("max_out", max_out, exp_max);
    check("max_model", max_out, mx);
`ifdef SOFTMAX_MAX_CTRL_ARGMAX_EN
    check("idx_out", idx_out, exp_idx);
    check("idx_model", idx_out, ix);
`endif
    @(negedge clk); start = 1'b0;
    #1 check("post_done", done, 0);
    check("post_busy", busy, 0);
    if (pulse) begin
      @(negedge clk);
      #1 check("ignored_start_busy", busy, 0);
      check("ignored_start_done", done, 0);
    end
  endtask

  typedef struct {
    logic [NE-1:0][DW-1:0] d;
    logic [NE-1:0][1:0]    gaps;
    logic [DW-1:0]         exp_max;
    int                    exp_idx;
    logic                  pulse;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{v4(3, -5, 7, 2),                 '0,              16'd7,      2, 1'b0};
    tbl[1] = '{v4(-8, -3, -3, -10),             '0,              16'hFFFD,   1, 1'b0};
    tbl[2] = '{v4(3, -5, 7, 2),                 {2'd1, 2'd3, 2'd2, 2'd1}, 16'd7, 2, 1'b0};
    tbl[3] = '{v4(-32768, 32767, -1, 0),        '0,              16'h7FFF,   1, 1'b0};
    tbl[4] = '{v4(-32768, -32768, -32768, -32768), '0,           16'h8000,   0, 1'b0};
    tbl[5] = '{v4(3, -5, 7, 2),                 {2'd0, 2'd1, 2'd0, 2'd0}, 16'd7, 2, 1'b1};

    // reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_set", set_reg, 0);
    check("rst_done", done, 0);
    check("rst_max", max_out, 0);
`ifdef SOFTMAX_MAX_CTRL_ARGMAX_EN
    check("rst_idx", idx_out, 0);
`endif
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    foreach (tbl[k]) run_vec(tbl[k].d, tbl[k].gaps, tbl[k].exp_max, tbl[k].exp_idx, tbl[k].pulse);

    // reset in the middle of a vector
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; in_data = 16'd40;
    @(negedge clk); in_data = 16'd50;
    @(negedge clk); in_valid = 1'b1; in_data = 16'd60;
    #1 rst_n = 1'b0;
    #1 check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_set", set_reg, 0);
    check("midrst_done", done, 0);
    check("midrst_max", max_out, 0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_vec(v4(-100, -200, -50, -75), '0, 16'hFFCE, 2, 1'b0);

    // random vectors against the reference model
    for (int n = 0; n < 20; n++) begin
      logic [NE-1:0][DW-1:0] d;
      logic [NE-1:0][1:0]    gaps;
      logic [DW-1:0]         mx;
      int                    ix;
      logic [NE-1:0]         loads;
      for (int i = 0; i < NE; i++) begin
        d[i]    = (n % 2 == 0) ? DW'($urandom_range(0, 3)) - DW'(2) : DW'($urandom);
        gaps[i] = 2'($urandom_range(0, 2));
      end
      ref_model(d, mx, ix, loads);
      run_vec(d, gaps, mx, ix, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/softmax_max_ctrl.md
SOFTMAX_MAX_CTRL -- requirements
Module: softmax_max_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: element and register width, signed two's complement.
REQ-002 Parameter NUM_ELEM, default 8: elements per vector, range 1..255.
REQ-003 Derived CNT_W = clog2(NUM_ELEM+1): element counter width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a vector; honoured only in IDLE.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_data  input  DATA_WIDTH  signed element.
REQ-009 in_ready  output  1  controller accepts an element; beat = in_valid & in_ready.
REQ-010 set_reg  output  1  load enable to the external max-holding register.
REQ-011 reg_in  output  DATA_WIDTH  load data to the register; always equals in_data.
REQ-012 reg_out  input  DATA_WIDTH  current register contents, fed back for comparison.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse; the result is valid in that cycle.
REQ-015 max_out  output  DATA_WIDTH  equals reg_out; meaningful only while done=1.

Function
REQ-016 FSM states: IDLE, FIRST, SCAN and DONE.
REQ-017 IDLE: in_ready=0, set_reg=0; start=1 -> FIRST and clear count to 0.
REQ-018 FIRST: in_ready=1; on a beat, set_reg=1 unconditionally and count becomes 1.
REQ-019 FIRST exit on a beat: NUM_ELEM=1 -> DONE, otherwise -> SCAN.
REQ-020 SCAN: in_ready=1; on a beat, set_reg=1 only if in_data > reg_out (signed, strict), and count increments.
REQ-021 SCAN exit: the beat that brings count to NUM_ELEM -> DONE.
REQ-022 set_reg, in_ready and reg_in are combinational from state, in_valid, in_data and reg_out; the register captures on the same edge as the beat.
REQ-023 Beat latency: zero cycles of controller latency; the register updates one edge after set_reg.
REQ-024 DONE: lasts exactly 1 cycle with done=1 and in_ready=0, then -> IDLE.
REQ-025 Done timing: done asserts the cycle after the final beat.
REQ-026 Stall: cycles with in_valid=0 do not change state, count or register.
REQ-027 start in any state other than IDLE is ignored, including a start in the DONE cycle.
REQ-028 Ties keep the earlier element, because the comparison is strict.
REQ-029 No arithmetic overflow is possible; the comparison covers the full signed range.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, count 0, done 0, busy 0, in_ready 0, set_reg 0.
REQ-031 Reset mid-vector discards all progress; after release, a new start begins a fresh vector.
REQ-032 The external register shares rst_n, so max_out is 0 after reset.

Configuration
REQ-033 Macro SOFTMAX_MAX_CTRL_ARGMAX_EN defined: adds output idx_out, width CNT_W.
REQ-034 idx_out loads the count value of the beat on every beat where set_reg=1.
REQ-035 idx_out resets to 0 and is valid while done=1.
REQ-036 Macro SOFTMAX_MAX_CTRL_ARGMAX_EN undefined: idx_out and its logic are absent, and all other behaviour is identical.

Verification (DATA_WIDTH=16, NUM_ELEM=4, register model = load-enable register on the same clock and reset)
REQ-037 Scenario 1: start, then back-to-back beats 3, -5, 7, 2 -> set_reg high on beats 0 and 2; done one cycle after the last beat; max_out=7; idx_out=2.
REQ-038 Scenario 2: beats -8, -3, -3, -10 -> max_out=-3 and idx_out=1 (tie keeps the first occurrence).
REQ-039 Scenario 3: same data as scenario 1 with in_valid low for 1-3 cycles between beats -> identical result; done 1 cycle after the 4th beat.
REQ-040 Scenario 4: beats -32768, 32767, -1, 0 -> max_out=32767; beats of all -32768 -> max_out=-32768, idx_out=0.
REQ-041 Scenario 5: start pulsed during SCAN and during DONE -> ignored; exactly one done per accepted start.
REQ-042 Scenario 6: rst_n low after 2 beats -> immediately busy=0, in_ready=0, done=0, max_out=0; a new start plus 4 beats gives the correct max.
